// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker: pops PS/2 Set-2 bytes, tracks held keys with n-key rollover and
// keeps a BCD count of genuine presses.
module ps2_key_tracker #(
  parameter int SLOTS = 4,
  parameter int CNT_DIGITS = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 kb_data,
  input  logic                       kb_ready,
  input  logic                       kb_overflow,
  output logic                       kb_nextdata_n,
  output logic [7:0]                 key_code,
  output logic                       key_ext,
  output logic                       key_down,
  output logic [$clog2(SLOTS+1)-1:0] held_cnt,
  output logic                       press_pulse,
  output logic                       release_pulse,
  output logic [4*CNT_DIGITS-1:0]    press_bcd,
  output logic                       err
);
  localparam int CW = $clog2(SLOTS+1);
  typedef enum logic {WAIT, GAP} pop_t;
  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} prs_t;
  pop_t pop_st, pop_nx;
  prs_t prs_st, prs_nx;
  logic pop, mk, bk, any_hit, full, ins, rel, carry;
  logic [8:0] id;
  logic [8:0] tab [SLOTS];
  logic [SLOTS-1:0] vld, hit, free_oh;
  logic [4*CNT_DIGITS-1:0] bcd_nx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pop_st <= WAIT;
      prs_st <= IDLE;
    end else begin
      pop_st <= pop_nx;
      prs_st <= prs_nx;
    end
  end

  always_comb begin
    pop_nx = pop_st == GAP ? WAIT : kb_ready ? GAP : WAIT;
    prs_nx = !pop ? prs_st :
             kb_data == 8'hE0 ? EXT :
             kb_data == 8'hF0 ? (prs_st == IDLE ? BRK : prs_st == EXT ? EXT_BRK : prs_st) :
             IDLE;
  end

  // The strobe is gated by reset so the FIFO never sees a pop while we are held in reset.
  always_comb begin
    pop = rst && pop_st == WAIT && kb_ready;
    kb_nextdata_n = !pop;
    id = {prs_st == EXT || prs_st == EXT_BRK, kb_data};
    mk = pop && kb_data != 8'hE0 && kb_data != 8'hF0 && (prs_st == IDLE || prs_st == EXT);
    bk = pop && kb_data != 8'hE0 && kb_data != 8'hF0 && (prs_st == BRK || prs_st == EXT_BRK);
  end

  always_comb begin
    for (int i = 0; i < SLOTS; i++) hit[i] = vld[i] && tab[i] == id;
    any_hit = |hit;
    full = &vld;
    free_oh = ~vld & (vld + SLOTS'(1));
    ins = mk && !any_hit && !full;
    rel = bk && any_hit;
  end

  always_comb begin
    bcd_nx = press_bcd;
    carry = 1'b1;
    for (int d = 0; d < CNT_DIGITS; d++) begin
      if (carry) begin
        bcd_nx[4*d +: 4] = press_bcd[4*d +: 4] == 4'd9 ? 4'd0 : press_bcd[4*d +: 4] + 4'd1;
        carry = press_bcd[4*d +: 4] == 4'd9;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld <= '0;
      for (int i = 0; i < SLOTS; i++) tab[i] <= '0;
      key_code <= '0;
      key_ext <= 1'b0;
      held_cnt <= '0;
      press_pulse <= 1'b0;
      release_pulse <= 1'b0;
      press_bcd <= '0;
      err <= 1'b0;
    end else begin
      press_pulse <= ins;
      release_pulse <= rel;
      held_cnt <= ins ? held_cnt + CW'(1) : rel ? held_cnt - CW'(1) : held_cnt;
      err <= err || kb_overflow || (mk && !any_hit && full);
      if (ins) begin
        key_code <= kb_data;
        key_ext <= id[8];
        press_bcd <= bcd_nx;
      end
      for (int i = 0; i < SLOTS; i++) begin
        if (ins && free_oh[i]) begin
          vld[i] <= 1'b1;
          tab[i] <= id;
        end else if (rel && hit[i]) begin
          vld[i] <= 1'b0;
        end
      end
    end
  end

  assign key_down = held_cnt != '0;
endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb_ps2_key_tracker: FIFO-model driver, reference key tracker and pulse scoreboard.
module tb_ps2_key_tracker;
  localparam int SLOTS = 4;
  localparam int CNT_DIGITS = 2;
  logic clk = 0, rst = 1, kb_ready = 0, kb_overflow = 0;
  logic [7:0] kb_data = 0;
  logic kb_nextdata_n, key_ext, key_down, press_pulse, release_pulse, err;
  logic [7:0] key_code, press_bcd;
  logic [2:0] held_cnt;

  ps2_key_tracker #(.SLOTS(SLOTS), .CNT_DIGITS(CNT_DIGITS)) dut (
    .clk(clk), .rst(rst), .kb_data(kb_data), .kb_ready(kb_ready), .kb_overflow(kb_overflow),
    .kb_nextdata_n(kb_nextdata_n), .key_code(key_code), .key_ext(key_ext), .key_down(key_down),
    .held_cnt(held_cnt), .press_pulse(press_pulse), .release_pulse(release_pulse),
    .press_bcd(press_bcd), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {bit rel; logic [7:0] code; bit ext; int held; int cnt; bit err;} ev_t;
  ev_t exp_q[$];
  logic [7:0] fifo[$];
  logic [8:0] held[$];
  bit m_ext, m_brk, m_err, will_pop, prev_low;
  int m_cnt;
  logic [8:0] m_last;
  int n_cmp = 0, n_bad = 0;

  task automatic cmp(string n, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
    end
  endtask

  function automatic int bcd(int n);
    return ((n / 10) % 10) * 16 + n % 10;
  endfunction

  // Reference: pending prefix flags plus a list of held ids; pulses are predicted per byte.
  task automatic send(logic [7:0] b);
    logic [8:0] id;
    int idx[$];
    fifo.push_back(b);
    if (b == 8'hE0) begin
      m_ext = 1;
      m_brk = 0;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else begin
      id = {m_ext, b};
      idx = held.find_first_index(item) with (item == id);
      if (!m_brk) begin
        if (idx.size() == 0) begin
          if (held.size() < SLOTS) begin
            held.push_back(id);
            m_cnt = (m_cnt + 1) % 100;
            m_last = id;
            exp_q.push_back('{0, b, m_ext, held.size(), m_cnt, m_err});
          end else m_err = 1;
        end
      end else if (idx.size() != 0) begin
        held.delete(idx[0]);
        exp_q.push_back('{1, m_last[7:0], m_last[8], held.size(), m_cnt, m_err});
      end
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  always @(negedge clk) begin
    if (will_pop && fifo.size() != 0) void'(fifo.pop_front());
    will_pop = 0;
    kb_ready = rst && fifo.size() != 0 && $urandom_range(0, 3) != 0;
    kb_data = fifo.size() != 0 ? fifo[0] : 8'h00;
    #1;
    if (kb_nextdata_n === 1'b0) begin
      cmp("pop_while_not_ready", kb_ready, 1);
      cmp("pop_strobe_width", prev_low, 0);
      will_pop = 1;
    end
    prev_low = kb_nextdata_n === 1'b0;
  end

  always @(negedge clk) begin
    ev_t e;
    if (rst && (press_pulse === 1'b1 || release_pulse === 1'b1)) begin
      if (exp_q.size() == 0) begin
        cmp("unexpected_pulse", {press_pulse, release_pulse}, 0);
      end else begin
        e = exp_q.pop_front();
        cmp("pulse_kind", {press_pulse, release_pulse}, e.rel ? 2'b01 : 2'b10);
        cmp("ev_key_code", key_code, e.code);
        cmp("ev_key_ext", key_ext, e.ext);
        cmp("ev_held_cnt", held_cnt, e.held);
        cmp("ev_key_down", key_down, e.held != 0);
        cmp("ev_press_bcd", press_bcd, bcd(e.cnt));
        cmp("ev_err", err, e.err);
      end
    end
  end

  task automatic drain();
    int t = 0;
    while ((fifo.size() != 0 || will_pop) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) cmp("drain_timeout", fifo.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_state(string n);
    cmp({n, "_held_cnt"}, held_cnt, held.size());
    cmp({n, "_key_down"}, key_down, held.size() != 0);
    cmp({n, "_press_bcd"}, press_bcd, bcd(m_cnt));
    cmp({n, "_err"}, err, m_err);
    cmp({n, "_key_code"}, key_code, m_last[7:0]);
    cmp({n, "_key_ext"}, key_ext, m_last[8]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #3;
    rst = 0;
    fifo.delete();
    will_pop = 0;
    prev_low = 0;
    kb_ready = 0;
    #1;
    cmp("rst_nextdata_n", kb_nextdata_n, 1);
    cmp("rst_key_code", key_code, 0);
    cmp("rst_key_ext", key_ext, 0);
    cmp("rst_key_down", key_down, 0);
    cmp("rst_held_cnt", held_cnt, 0);
    cmp("rst_pulses", {press_pulse, release_pulse}, 0);
    cmp("rst_press_bcd", press_bcd, 0);
    cmp("rst_err", err, 0);
    cmp("rst_pending_events", exp_q.size(), 0);
    exp_q.delete();
    held.delete();
    m_ext = 0;
    m_brk = 0;
    m_err = 0;
    m_cnt = 0;
    m_last = 0;
    @(negedge clk);
    rst = 1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] pool [7] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h75, 8'h4D};
    logic [7:0] c;
    do_reset();
    send(8'h1C); send(8'hF0); send(8'h1C);
    drain();
    check_state("single");
    cmp("single_bcd", press_bcd, 8'h01);
    repeat (6) send(8'h1C);
    drain();
    cmp("typematic_key_down", key_down, 1);
    cmp("typematic_bcd", press_bcd, 8'h02);
    send(8'hF0); send(8'h1C);
    drain();
    check_state("typematic");
    send(8'h75); send(8'hE0); send(8'h75);
    drain();
    cmp("ext_held", held_cnt, 2);
    cmp("ext_key_ext", key_ext, 1);
    cmp("ext_key_code", key_code, 8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    drain();
    cmp("ext_rel_held", held_cnt, 1);
    check_state("ext_rel");
    do_reset();
    foreach (pool[i]) if (i < 5) send(pool[i]);
    drain();
    cmp("roll_held", held_cnt, 4);
    cmp("roll_bcd", press_bcd, 8'h04);
    cmp("roll_err", err, 1);
    cmp("roll_key_code", key_code, 8'h23);
    send(8'hF0); send(8'h4D);
    drain();
    check_state("stray_break");
    do_reset();
    for (int i = 0; i < 99; i++) begin
      c = pool[$urandom_range(0, 6)];
      send(c); send(8'hF0); send(c);
    end
    drain();
    cmp("bcd_99", press_bcd, 8'h99);
    send(8'h1C); send(8'hF0); send(8'h1C);
    drain();
    cmp("bcd_wrap", press_bcd, 8'h00);
    cmp("bcd_wrap_err", err, 0);
    send(8'hE0); send(8'hF0);
    drain();
    do_reset();
    send(8'h75);
    drain();
    cmp("midrst_key_ext", key_ext, 0);
    cmp("midrst_bcd", press_bcd, 8'h01);
    check_state("midrst");
    do_reset();
    for (int i = 0; i < 400; i++) begin
      c = pool[$urandom_range(0, 6)];
      if ($urandom_range(0, 9) == 0) send($urandom_range(0, 1) ? 8'hE0 : 8'hF0);
      if ($urandom_range(0, 1)) send(8'hE0);
      if ($urandom_range(0, 1)) send(8'hF0);
      send(c);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
    end
    drain();
    check_state("random");
    do_reset();
    @(negedge clk);
    kb_overflow = 1;
    m_err = 1;
    @(negedge clk);
    kb_overflow = 0;
    cmp("overflow_err", err, 1);
    send(8'h24);
    drain();
    check_state("after_overflow");
    cmp("leftover_events", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
